regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised multi-port register file with write-through bypass and a per-register outstanding-write scoreboard, the next-generation replacement for the decode-stage register file. Decode reads operands through NRD combinational ports and reserves destinations with an issue request; writeback commits through NWR ports. Per-port busy flags give the hazard unit a direct stall source without address comparison chains.

## Interface
- DW, 32, data width
- AW, 5, address width; register count is 2**AW
- NRD, 2, read ports (1..4)
- NWR, 1, write ports (1..2)
- CNT_W, 2, width of each outstanding-write counter
- ZERO_REG, 1, 1 = register 0 hardwired to zero
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high
- ra  in  NRD*AW  read addresses, port i at [i*AW +: AW]
- rd  out  NRD*DW  read data, port i at [i*DW +: DW]
- rbusy  out  NRD  port i source has an outstanding write not completing this cycle
- we  in  NWR  write enables
- wa  in  NWR*AW  write addresses
- wd  in  NWR*DW  write data
- iss_valid  in  1  reserve iss_addr as destination of a newly issued instruction
- iss_addr  in  AW  register being reserved
- iss_ready  out  1  reservation can be accepted this cycle
- err  out  1  sticky: writeback to a register whose counter was zero

## Operation
- Storage: 2**AW x DW array plus 2**AW counters cnt[r] of CNT_W bits.
- Write: on the rising edge, each port j with we[j] writes wd[j] to wa[j]. Multiple ports to one address: highest j wins.
- Read: rd[i] is combinational. If any we[j] with wa[j]==ra[i] this cycle, rd[i] = wd of highest such j (bypass); else array value. No half-cycle write trick.
- Zero register (ZERO_REG=1): reads of 0 return 0; writes, bypass, issue and counting for address 0 are ignored; rbusy for address 0 is 0.
- Scoreboard, per register r each edge: next = cnt[r] + inc - dec, where inc = 1 when iss_valid & iss_ready & iss_addr==r, and dec = number of write ports with we & wa==r, limited to cnt[r] + inc.
- If dec requested exceeds cnt[r] + inc, counter floors at 0 and err sets; err clears only on reset.
- iss_ready = 0 when cnt[iss_addr] == 2**CNT_W-1 and no write to iss_addr this cycle; otherwise 1 (also 1 when iss_addr is the hardwired zero register). iss_valid with iss_ready=0 has no effect; the issuer holds.
- rbusy[i] = (cnt[ra[i]] - matching writes this cycle) > 0, floored at 0. Same-cycle issue does not affect rbusy.
- Same-cycle issue and writeback to one register: net counter change is +1 - dec (an older writer completes, a newer one reserves).

## Timing
- Read and bypass latency: 0 cycles (combinational). Write visible from the array the cycle after the edge.
- Scoreboard update: 1 edge; rbusy reflects the new count in the next cycle.
- Reset (asynchronous, any time, including mid-operation): array all zero, all counters 0, err 0. While reset is held, rd = 0 for every address unless bypassed, rbusy = 0 and iss_ready = 1. Writes and issues during reset are discarded.
- No internal pipelining. All outputs are combinational from state plus current inputs; the critical path is the bypass mux plus counter subtract.

## Test plan
- Reset, then write 0xDEADBEEF to r5 via port 0 and read r5 on both ports the same cycle -> rd = 0xDEADBEEF via bypass; the following cycle it is read from the array.
- Write 0x12345678 to r0 with ZERO_REG=1 -> rd(r0) = 0 both cycles; issue to r0 leaves rbusy = 0.
- NWR=2: ports 0 and 1 write r7 with 0x1 and 0x2 in the same cycle -> stored 0x2; cnt[7] starts at 2 and ends at 0.
- Issue r3 three times with CNT_W=2 -> rbusy(r3) = 1 and iss_ready = 0 for r3. A fourth issue is held with cnt = 3. Three writebacks -> rbusy drops in the cycle of the third write.
- Issue r9 and write r9 in the same cycle with cnt[9] = 1 -> cnt stays 1 and rbusy stays 1. A write to r4 with cnt[4] = 0 -> err = 1, held until reset.
- Assert reset mid-sequence with counters nonzero -> all rbusy = 0, err = 0 and reads = 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/regfile_sb.sv
// Multi-port register file with write-through bypass and a per-register
// outstanding-write counter that supplies per-port busy flags to hazard logic.
module regfile_sb #(
   parameter int DW       = 32,
   parameter int AW       = 5,
   parameter int NRD      = 2,
   parameter int NWR      = 1,
   parameter int CNT_W    = 2,
   parameter int ZERO_REG = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NRD*AW-1:0]   ra_i,
   output logic [NRD*DW-1:0]   rd_o,
   output logic [NRD-1:0]      rbusy_o,
   input  logic [NWR-1:0]      we_i,
   input  logic [NWR*AW-1:0]   wa_i,
   input  logic [NWR*DW-1:0]   wd_i,
   input  logic                iss_valid_i,
   input  logic [AW-1:0]       iss_addr_i,
   output logic                iss_ready_o,
   output logic                err_o
);

   localparam int NREG = 2**AW;
   // Wide enough for count + issue and for up to NWR decrements
   localparam int SW   = CNT_W + 2;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [DW-1:0]    mem_q [NREG];
   logic [DW-1:0]    mem_d [NREG];
   logic [CNT_W-1:0] cnt_q [NREG];
   logic [CNT_W-1:0] cnt_d [NREG];
   logic             err_q;
   logic             err_d;

   logic [NWR-1:0]   wen_s;
   logic [AW-1:0]    wa_s  [NWR];
   logic [DW-1:0]    wd_s  [NWR];
   logic [AW-1:0]    ra_s  [NRD];
   logic [DW-1:0]    rdat_s[NRD];
   logic [SW-1:0]    rhit_s[NRD];
   logic             iss_hit_s;
   logic             iss_fire_s;
   logic [SW-1:0]    sum_s [NREG];
   logic [SW-1:0]    dec_s [NREG];

   function automatic logic is_zero(input logic [AW-1:0] a);
      return (ZERO_REG != 0) && (a == '0);
   endfunction

   // Writes to the hardwired zero register are dropped here, so they never
   // reach storage, bypass or the counters.
   always_comb begin
      for (int j = 0; j < NWR; j++) begin
         wa_s[j]  = wa_i[j*AW +: AW];
         wd_s[j]  = wd_i[j*DW +: DW];
         wen_s[j] = we_i[j] && !is_zero(wa_s[j]);
      end
   end

   always_comb begin
      rd_o    = '0;
      rbusy_o = '0;
      for (int i = 0; i < NRD; i++) begin
         ra_s[i]   = ra_i[i*AW +: AW];
         rdat_s[i] = mem_q[ra_s[i]];
         rhit_s[i] = '0;
         for (int j = 0; j < NWR; j++) begin
            if (wen_s[j] && (wa_s[j] == ra_s[i])) begin
               rdat_s[i] = wd_s[j];
               rhit_s[i] = rhit_s[i] + SW'(1);
            end
         end
         if (is_zero(ra_s[i])) begin
            rdat_s[i] = '0;
         end
         rd_o[i*DW +: DW] = rdat_s[i];
         rbusy_o[i]       = SW'(cnt_q[ra_s[i]]) > rhit_s[i];
      end
   end

   // A saturated counter can still accept an issue when a writeback frees a slot
   always_comb begin
      iss_hit_s = 1'b0;
      for (int j = 0; j < NWR; j++) begin
         if (wen_s[j] && (wa_s[j] == iss_addr_i)) begin
            iss_hit_s = 1'b1;
         end
      end
      iss_ready_o = is_zero(iss_addr_i) || iss_hit_s || (cnt_q[iss_addr_i] != CNT_MAX);
      iss_fire_s  = iss_valid_i && iss_ready_o && !is_zero(iss_addr_i);
   end

   always_comb begin
      err_d = err_q;
      for (int r = 0; r < NREG; r++) begin
         sum_s[r] = SW'(cnt_q[r]) + SW'(iss_fire_s && (iss_addr_i == AW'(r)));
         dec_s[r] = '0;
         for (int j = 0; j < NWR; j++) begin
            if (wen_s[j] && (wa_s[j] == AW'(r))) begin
               dec_s[r] = dec_s[r] + SW'(1);
            end
         end
         if (dec_s[r] > sum_s[r]) begin
            cnt_d[r] = '0;
            err_d    = 1'b1;
         end else begin
            cnt_d[r] = CNT_W'(sum_s[r] - dec_s[r]);
         end
      end
   end

   // Ascending port order lets the highest-numbered writer win
   always_comb begin
      for (int r = 0; r < NREG; r++) begin
         mem_d[r] = mem_q[r];
      end
      for (int j = 0; j < NWR; j++) begin
         if (wen_s[j]) begin
            mem_d[wa_s[j]] = wd_s[j];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int r = 0; r < NREG; r++) begin
            mem_q[r] <= '0;
            cnt_q[r] <= '0;
         end
         err_q <= 1'b0;
      end else begin
         for (int r = 0; r < NREG; r++) begin
            mem_q[r] <= mem_d[r];
            cnt_q[r] <= cnt_d[r];
         end
         err_q <= err_d;
      end
   end

   assign err_o = err_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboarded bench for regfile_sb: directed scenarios plus a random phase,
// with expected outputs queued at drive time and popped when sampled.
module tb_regfile_sb;

   localparam int DW = 32, AW = 5, NRD = 2, NWR = 2, CNT_W = 2;

   logic                clk = 1'b0;
   logic                reset;
   logic [NRD*AW-1:0]   ra_i;
   logic [NRD*DW-1:0]   rd_o;
   logic [NRD-1:0]      rbusy_o;
   logic [NWR-1:0]      we_i;
   logic [NWR*AW-1:0]   wa_i;
   logic [NWR*DW-1:0]   wd_i;
   logic                iss_valid_i;
   logic [AW-1:0]       iss_addr_i;
   logic                iss_ready_o;
   logic                err_o;

   regfile_sb #(.DW(DW), .AW(AW), .NRD(NRD), .NWR(NWR), .CNT_W(CNT_W), .ZERO_REG(1)) dut (
      .clk(clk), .reset(reset), .ra_i(ra_i), .rd_o(rd_o), .rbusy_o(rbusy_o),
      .we_i(we_i), .wa_i(wa_i), .wd_i(wd_i), .iss_valid_i(iss_valid_i),
      .iss_addr_i(iss_addr_i), .iss_ready_o(iss_ready_o), .err_o(err_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] rd0;
      logic [31:0] rd1;
      logic [1:0]  busy;
      logic        rdy;
      logic        err;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] m_mem[32];
   int          m_cnt[32];
   logic        m_err;
   int          n_vec = 0;
   int          n_err = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_clear();
      for (int r = 0; r < 32; r++) begin
         m_mem[r] = 32'h0;
         m_cnt[r] = 0;
      end
      m_err = 1'b0;
   endtask

   function automatic logic [4:0] w_addr(input int j);
      return wa_i[j*AW +: AW];
   endfunction

   function automatic logic model_ready();
      logic [4:0] a = iss_addr_i;
      if (a == 5'd0) return 1'b1;
      if (m_cnt[a] < 3) return 1'b1;
      for (int j = 0; j < NWR; j++)
         if (we_i[j] && w_addr(j) == a) return 1'b1;
      return 1'b0;
   endfunction

   function automatic exp_t predict();
      exp_t        e;
      logic [4:0]  a;
      logic [31:0] v;
      int          hits;
      for (int i = 0; i < NRD; i++) begin
         a    = ra_i[i*AW +: AW];
         v    = m_mem[a];
         hits = 0;
         for (int j = 0; j < NWR; j++)
            if (we_i[j] && w_addr(j) == a && a != 5'd0) begin
               v = wd_i[j*DW +: DW];
               hits++;
            end
         if (a == 5'd0) v = 32'h0;
         if (i == 0) e.rd0 = v; else e.rd1 = v;
         e.busy[i] = (a != 5'd0) && (m_cnt[a] - hits > 0);
      end
      e.rdy = model_ready();
      e.err = m_err;
      return e;
   endfunction

   task automatic model_edge();
      logic fire;
      int   tot;
      fire = iss_valid_i && model_ready() && iss_addr_i != 5'd0;
      for (int r = 1; r < 32; r++) begin
         tot = m_cnt[r] + ((fire && iss_addr_i == 5'(r)) ? 1 : 0);
         for (int j = 0; j < NWR; j++)
            if (we_i[j] && w_addr(j) == 5'(r)) tot--;
         if (tot < 0) begin
            tot   = 0;
            m_err = 1'b1;
         end
         m_cnt[r] = tot;
      end
      for (int j = 0; j < NWR; j++)
         if (we_i[j] && w_addr(j) != 5'd0) m_mem[w_addr(j)] = wd_i[j*DW +: DW];
   endtask

   task automatic drive(input logic w0, input logic [4:0] a0, input logic [31:0] d0,
                        input logic w1, input logic [4:0] a1, input logic [31:0] d1,
                        input logic iv, input logic [4:0] ia,
                        input logic [4:0] r0, input logic [4:0] r1);
      we_i = {w1, w0};
      wa_i = {a1, a0};
      wd_i = {d1, d0};
      iss_valid_i = iv;
      iss_addr_i  = ia;
      ra_i = {r1, r0};
   endtask

   task automatic idle(input logic [4:0] r0, input logic [4:0] r1);
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, r0, r1);
   endtask

   task automatic issue(input logic [4:0] a);
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, a, a, 5'd0);
   endtask

   // Called one time unit after a rising edge with inputs already driven.
   task automatic step();
      exp_t e;
      exp_q.push_back(predict());
      #2;
      e = exp_q.pop_front();
      check_val("rd0",   rd_o[31:0],  e.rd0);
      check_val("rd1",   rd_o[63:32], e.rd1);
      check_val("rbusy", 32'(rbusy_o), 32'(e.busy));
      check_val("ready", 32'(iss_ready_o), 32'(e.rdy));
      check_val("err",   32'(err_o), 32'(e.err));
      @(posedge clk);
      if (!reset) model_edge();
      #1;
   endtask

   initial begin
      reset = 1'b1;
      idle(5'd5, 5'd7);
      model_clear();
      #1;
      check_val("rst_rd0",   rd_o[31:0], 32'h0);
      check_val("rst_rbusy", 32'(rbusy_o), 32'h0);
      check_val("rst_ready", 32'(iss_ready_o), 32'h1);
      check_val("rst_err",   32'(err_o), 32'h0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Bypass then array read of r5
      drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd5);
      #1 check_val("byp_r5_p1", rd_o[63:32], 32'hDEADBEEF);
      step();
      idle(5'd5, 5'd5);
      #1 check_val("arr_r5", rd_o[31:0], 32'hDEADBEEF);
      step();

      // Zero register
      drive(1'b1, 5'd0, 32'h12345678, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
      #1 check_val("r0_byp", rd_o[31:0], 32'h0);
      step();
      idle(5'd0, 5'd0);
      step();
      issue(5'd0);
      step();
      idle(5'd0, 5'd0);
      #1 check_val("r0_busy", 32'(rbusy_o), 32'h0);
      step();

      // Two ports to r7, highest wins, count 2 -> 0
      issue(5'd7);
      step();
      issue(5'd7);
      step();
      idle(5'd7, 5'd0);
      #1 check_val("r7_busy2", 32'(rbusy_o[0]), 32'h1);
      step();
      drive(1'b1, 5'd7, 32'h1, 1'b1, 5'd7, 32'h2, 1'b0, 5'd0, 5'd7, 5'd0);
      #1 check_val("r7_byp_hi", rd_o[31:0], 32'h2);
      step();
      idle(5'd7, 5'd0);
      #1 check_val("r7_arr", rd_o[31:0], 32'h2);
      check_val("r7_idle", 32'(rbusy_o[0]), 32'h0);
      step();

      // Saturate r3, hold fourth issue, drain
      for (int k = 0; k < 3; k++) begin
         issue(5'd3);
         step();
      end
      for (int k = 0; k < 2; k++) begin
         issue(5'd3);
         #1 check_val("r3_full", 32'(iss_ready_o), 32'h0);
         step();
      end
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 5'd3, 32'(k), 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd0);
         #1 check_val("r3_drain", 32'(rbusy_o[0]), (k == 2) ? 32'h0 : 32'h1);
         step();
      end

      // Same-cycle issue+write on r9, then underflow on r4
      issue(5'd9);
      step();
      drive(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd0);
      step();
      idle(5'd9, 5'd0);
      #1 check_val("r9_busy", 32'(rbusy_o[0]), 32'h1);
      step();
      drive(1'b1, 5'd4, 32'hAA, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd0);
      step();
      for (int k = 0; k < 3; k++) begin
         idle(5'd4, 5'd9);
         #1 check_val("err_sticky", 32'(err_o), 32'h1);
         step();
      end

      // Random traffic in a small address window
      for (int k = 0; k < 300; k++) begin
         drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
               1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
               1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
         step();
      end

      // Asynchronous reset with counters nonzero
      issue(5'd3);
      step();
      issue(5'd5);
      step();
      idle(5'd3, 5'd5);
      iss_addr_i = 5'd3;
      #2 reset = 1'b1;
      #1;
      check_val("arst_rbusy", 32'(rbusy_o), 32'h0);
      check_val("arst_err",   32'(err_o), 32'h0);
      check_val("arst_rd0",   rd_o[31:0], 32'h0);
      check_val("arst_rd1",   rd_o[63:32], 32'h0);
      check_val("arst_ready", 32'(iss_ready_o), 32'h1);
      model_clear();
      drive(1'b1, 5'd6, 32'h55, 1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 5'd3, 5'd5);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      idle(5'd6, 5'd6);
      #1 check_val("rst_discard", rd_o[31:0], 32'h0);
      check_val("rst_no_iss", 32'(rbusy_o), 32'h0);
      @(posedge clk);
      #1;
      for (int k = 0; k < 40; k++) begin
         drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
               1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
               1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
